// File: rtl/prio_arb_pkg.sv
// Shared definitions for the priority arbiter: FSM state encoding and
// default configuration constants.
// Optional feature macro: PRIO_ARB_RR_EN (round-robin selection).
package prio_arb_pkg;

    // Default number of request channels.
    localparam int DEF_N        = 4;

    // Default maximum consecutive grant cycles while others wait.
    localparam int DEF_MAX_HOLD = 8;

    // Width of the hold counter.
    localparam int HOLD_W       = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/prio_arb_pick.sv
// Masked winner selection: scans the request vector starting at start_i,
// wrapping around, and returns the first active request as a one-hot
// vector and an index. With start_i = 0 this is a plain fixed-priority
// chain where the lowest index wins.
module prio_arb_pick
    import prio_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = $clog2(DEF_N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Rotating first-one search; the first hit in scan order wins.
    always_comb begin
        int         pos;
        logic [W-1:0] p;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        p     = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            p = pos[W-1:0];
            if (!any_o && req_i[p]) begin
                any_o    = 1'b1;
                gnt_o[p] = 1'b1;
                idx_o    = p;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// Hold-limited arbiter with registered one-hot grant.
// A channel keeps the grant while it requests, unless it has held the
// grant for MAX_HOLD cycles and someone else is waiting. Handover to the
// next winner is back-to-back with no idle cycle.
// Optional feature macro: PRIO_ARB_RR_EN selects round-robin search
// starting after the last owner; when undefined, lowest index wins.
module prio_arbiter
    import prio_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    localparam int W       = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id,
    output logic         gnt_valid
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [W-1:0]      gnt_id_q, gnt_id_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [N-1:0]      cand;
    logic [W-1:0]      start;
    logic [N-1:0]      pick_gnt;
    logic [W-1:0]      pick_idx;
    logic              pick_any;

    logic              owner_req;
    logic              others_req;
    logic              expired;

`ifdef PRIO_ARB_RR_EN
    logic [W-1:0]      last_q, last_d;

    // Round-robin search starts one past the most recent owner.
    always_comb begin
        if (last_q == W'(N - 1)) begin
            start = '0;
        end else begin
            start = last_q + W'(1);
        end
    end
`else
    assign start = '0;
`endif

    assign owner_req  = |(req & gnt_q);
    assign others_req = |(req & ~gnt_q);
    assign expired    = (hold_q == HOLD_MAX) && others_req;

    prio_arb_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req_i   (cand),
        .start_i (start),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Next-state and next-grant selection for the IDLE/BUSY FSM.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        hold_d      = hold_q;
        cand        = req;
`ifdef PRIO_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                cand = req;
            end
            BUSY: begin
                // The owner is excluded both when it releases and when its
                // hold has expired; in the release case its bit is already low.
                cand = req & ~gnt_q;
                if (owner_req && !expired) begin
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: begin
                cand = req;
            end
        endcase

        if ((state_q == IDLE) || !owner_req || expired) begin
            if (pick_any) begin
                state_d     = BUSY;
                gnt_d       = pick_gnt;
                gnt_id_d    = pick_idx;
                gnt_valid_d = 1'b1;
                hold_d      = '0;
`ifdef PRIO_ARB_RR_EN
                last_d      = pick_idx;
`endif
            end else begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                hold_d      = '0;
            end
        end
    end

    // State, grant and hold registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            hold_q      <= hold_d;
        end
    end

`ifdef PRIO_ARB_RR_EN
    // Round-robin pointer: after reset the search begins at channel 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter with N=4, MAX_HOLD=4.
module tb_prio_arbiter;

    localparam int N = 4;
    localparam int W = 2;
`ifdef PRIO_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_id;
    logic         gnt_valid;

    int n_checks;
    int n_fail;

    prio_arbiter #(
        .N        (N),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [W-1:0] id;
        logic         v;
    } vec_t;

    vec_t tbl[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [N-1:0] eg,
                             input logic [W-1:0] eid, input logic ev);
        check({name, ".gnt"},       8'(gnt),       8'(eg));
        check({name, ".gnt_id"},    8'(gnt_id),    8'(eid));
        check({name, ".gnt_valid"}, 8'(gnt_valid), 8'(ev));
    endtask

    initial begin
        logic [N-1:0] eg;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = '0;

        // {rst_n, req, expected gnt, expected gnt_id, expected gnt_valid}
        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0110, 4'b0000, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1};
        tbl[3]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[4]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[7]  = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
        tbl[8]  = '{1'b1, 4'b1011, 4'b0010, 2'd1, 1'b1};
        tbl[9]  = RR ? '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1}
                     : '{1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1};
        tbl[10] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};

        step();
        for (int i = 0; i < 11; i++) begin
            rst_n = tbl[i].rst_n;
            req   = tbl[i].req;
            step();
            check_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].v);
        end

        // Hold expiry: two constant requesters alternate every 4 cycles.
        req = 4'b0011;
        for (int c = 1; c <= 12; c++) begin
            step();
            eg = (((c - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
            check_out($sformatf("hold_c%0d", c), eg,
                      (eg == 4'b0001) ? 2'd0 : 2'd1, 1'b1);
        end
        req = 4'b0000;
        step();
        check_out("hold_release", 4'b0000, 2'd0, 1'b0);

        // Lone owner never expires.
        req = 4'b1000;
        for (int c = 1; c <= 20; c++) begin
            step();
            check_out($sformatf("lone_c%0d", c), 4'b1000, 2'd3, 1'b1);
        end
        req = 4'b0000;
        step();
        check_out("lone_release", 4'b0000, 2'd0, 1'b0);

        // Wrap: last owner 3, then channels 0 and 3 request.
        req = 4'b1001;
        step();
        check_out("wrap", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        step();
        check_out("wrap_release", 4'b0000, 2'd0, 1'b0);

        // Reset asserted mid-grant drops the grant; re-grant after release.
        req = 4'b0100;
        step();
        check_out("mid_pre", 4'b0100, 2'd2, 1'b1);
        rst_n = 1'b0;
        step();
        check_out("mid_rst", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("mid_regrant", 4'b0100, 2'd2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of request channels, 2..16.
REQ-002 SHALL have parameter MAX_HOLD, default 8: maximum consecutive grant cycles per owner while others wait, 1..255.
REQ-003 SHALL define localparam W = $clog2(N): grant index width.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port req, input, N: per-channel request, level, held until the channel finishes.
REQ-007 SHALL have port gnt, output, N: registered one-hot grant; all-zero when no owner.
REQ-008 SHALL have port gnt_id, output, W: registered index of the owner; 0 when no owner.
REQ-009 SHALL have port gnt_valid, output, 1: registered, high iff gnt is non-zero.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one owner).
REQ-011 SHALL, in IDLE with any req bit high, grant the winner on the next rising edge (1-cycle latency) and enter BUSY.
REQ-012 SHALL, in IDLE with req all-zero, remain in IDLE with gnt = 0.
REQ-013 SHALL, in BUSY with req[owner] high and hold not expired, keep the same grant.
REQ-014 SHALL, in BUSY with req[owner] low, grant next cycle the winner among the remaining requests (back-to-back, no idle bubble), or go to IDLE if none remain.
REQ-015 SHALL keep an 8-bit hold counter that clears on every new grant and increments each BUSY cycle the owner keeps the grant, saturating at MAX_HOLD-1.
REQ-016 SHALL treat the hold as expired when hold_cnt == MAX_HOLD-1 and at least one other req bit is high; on the next edge, grant the winner among requests excluding the current owner.
REQ-017 SHALL NOT expire the hold while no other channel requests; the owner keeps the grant indefinitely in that case.
REQ-018 SHALL make winner selection without RR: lowest-index active request wins, as a fixed-priority chain.
REQ-019 SHALL always keep gnt one-hot or zero, with gnt_id and gnt_valid consistent with gnt on every cycle.
REQ-020 SHALL ignore req changes of non-owners while BUSY except through the REQ-014 and REQ-016 selection.

Reset
REQ-021 SHALL, on a clk edge with rst_n low, force the FSM to IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, hold_cnt = 0, and the RR pointer to N-1.
REQ-022 SHALL, on reset asserted mid-grant, drop the grant on that edge; first arbitration occurs on the first edge with rst_n high.

Configuration
REQ-023 SHALL, with macro PRIO_ARB_RR_EN defined, use round-robin selection: search starts at (last_owner+1) mod N and wraps; last_owner updates on every new grant.
REQ-024 SHALL, with PRIO_ARB_RR_EN undefined, use the fixed priority of REQ-018 and omit the pointer register.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, BUSY) and the default N/MAX_HOLD constants in shared package prio_arb_pkg.
REQ-026 SHALL place masked selection, meaning a request vector plus start index giving a one-hot winner and an index, in combinational sub-module prio_arb_pick, instantiated once.

Verification (N=4, MAX_HOLD=4)
REQ-027 SHALL verify: reset then req=4'b0110 -> one cycle later gnt=0010, gnt_id=1, gnt_valid=1.
REQ-028 SHALL verify, fixed priority: owner 1 drops req while req=4'b0100 -> next cycle gnt=0100, with no zero cycle between grants.
REQ-029 SHALL verify hold expiry: req=4'b0011 held constant -> gnt=0001 for exactly 4 cycles, then 0010; with RR, then back to 0001 after 4 more cycles.
REQ-030 SHALL verify a lone owner: req=4'b1000 held 20 cycles -> gnt=1000 all 20 cycles, with no expiry.
REQ-031 SHALL verify RR wrap: with RR, last owner 3 and req=4'b1001 -> gnt=0001.
REQ-032 SHALL verify reset mid-grant: rst_n low for one edge while gnt=0100 -> gnt=0, gnt_valid=0 after that edge; re-grant one cycle after release.
